ble_cmd_rx: RTL
===============

// Module: ble_cmd_rx
// PURPOSE
//  Upstream of the command processor. Receives 8N1 serial bytes from the BLE module on RX.
//  Assembles each pair of bytes into one 16-bit command word, high byte first.
//  Presents the word on cmd with a cmd_rdy/clr_cmd_rdy handshake.
//  Discards framing-errored bytes and stale half-commands so the byte pairing resynchronises.
// PARAMETERS
//  BAUD_DIV   2604  clk cycles per bit (50 MHz / 19200 baud); >= 16
//  TMO_BITS   32    max idle bit-times between high and low byte before the high byte is dropped
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  RX           in   1   serial input, idle high, asynchronous to clk
//  clr_cmd_rdy  in   1   consumer has captured cmd; clears cmd_rdy
//  cmd          out  16  assembled command {byte0, byte1}
//  cmd_rdy      out  1   cmd holds an unconsumed command
//  frm_err      out  1   1-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  Reset values
//   - cmd = 16'h0000, cmd_rdy = 0, frm_err = 0.
//   - Both RX sync flops preset to 1, so reset does not create a false start edge.
//   - Receiver is in IDLE and the assembler is in WAIT_HI.
//  Synchroniser
//   - RX passes through 2 flops. All decisions use the synchronised value rx_s.
//  Receiver FSM (IDLE, START, DATA, STOP)
//   - IDLE: a falling edge on rx_s loads baud_cnt = BAUD_DIV/2 and goes to START.
//   - START: at baud_cnt == 0, sample rx_s.
//     - If 1: false start; return to IDLE.
//     - If 0: reload baud_cnt = BAUD_DIV-1, clear bit_cnt, go to DATA.
//   - DATA: at each baud_cnt == 0, shift rx_s into the MSB of the shift register (LSB-first line order) and reload baud_cnt.
//     After 8 samples (bit_cnt == 7) go to STOP.
//   - STOP: at baud_cnt == 0, sample rx_s.
//     - If 1: byte_vld pulses for 1 cycle.
//     - If 0: frm_err pulses and no byte_vld.
//     - Either way, go to IDLE.
//   - Latency: byte_vld fires BAUD_DIV/2 + 9*BAUD_DIV cycles after the start edge (+2 for the synchroniser).
//  Assembler FSM (WAIT_HI, WAIT_LO)
//   - WAIT_HI: byte_vld latches hi_byte and goes to WAIT_LO. The timeout counter clears.
//   - WAIT_LO, byte_vld arrives:
//     - cmd <= {hi_byte, byte} and cmd_rdy <= 1 on the same edge.
//     - Return to WAIT_HI.
//   - WAIT_LO, no byte yet: the timeout counter increments every clk while the receiver is IDLE.
//     At TMO_BITS*BAUD_DIV it drops hi_byte and returns to WAIT_HI. cmd is untouched.
//   - frm_err in either state: return to WAIT_HI and discard any held hi_byte.
//  Handshake
//   - clr_cmd_rdy clears cmd_rdy on the next edge.
//   - cmd holds its value until the next completed pair.
//   - Completion and clr_cmd_rdy in the same cycle: completion wins, cmd_rdy = 1.
//   - A start edge while cmd_rdy = 1 is received normally; the consumer is not required to clear first.
//   - Overwrite of unconsumed cmd: the new word replaces cmd and cmd_rdy stays 1. No overrun flag.
//   - cmd changes only on a completion edge, never mid-transfer.
//  Widths
//   - baud_cnt is $clog2(BAUD_DIV) bits.
//   - The timeout counter is $clog2(TMO_BITS*BAUD_DIV+1) bits and saturates.
//   - bit_cnt is 3 bits.
//  Reset mid-operation
//   - Any partial byte or held hi_byte is lost.
//   - After release, the line must be seen idle (rx_s = 1) before any start edge is accepted.
// STRUCTURE
//  - Package ble_cmd_pkg: rx_state_t {IDLE,START,DATA,STOP}; asm_state_t {WAIT_HI,WAIT_LO}; default BAUD_DIV and TMO_BITS localparams.
//  - Sub-module uart_rx_core: synchroniser, baud and bit counters, receiver FSM.
//    Ports: clk, rst, RX, rx_byte[7:0], byte_vld, frm_err, rx_busy.
//  - ble_cmd_rx top holds the assembler FSM, the timeout counter, and the cmd/cmd_rdy registers.
// TESTING (BAUD_DIV=16, TMO_BITS=4 for sim)
//  1. Send bytes 8'hA5 then 8'h3C back to back
//     -> cmd = 16'hA53C, cmd_rdy rises 1 cycle after the 2nd stop-bit sample; frm_err stays 0.
//  2. Hold cmd_rdy, pulse clr_cmd_rdy
//     -> cmd_rdy = 0 next cycle, cmd still 16'hA53C.
//     Repeat with clr_cmd_rdy coincident with the next completion -> cmd_rdy = 1.
//  3. Send 8'h12 with stop bit forced 0, then 8'h34, 8'h56
//     -> frm_err pulses once; cmd = 16'h3456.
//  4. Send 8'h77, idle 5 bit-times, send 8'h01, 8'h02
//     -> high byte dropped; cmd = 16'h0102, never 16'h7701.
//  5. RX low glitch of 4 cycles while idle
//     -> false start rejected; no byte_vld, no frm_err.
//  6. Assert rst mid-DATA of the 2nd byte, release, send 8'hFF, 8'h00
//     -> outputs at reset values during rst; then cmd = 16'hFF00, cmd_rdy = 1.

Source files
------------

// File: rtl/ble_cmd_pkg.sv
// Shared types and default timing for the BLE command receiver.
package ble_cmd_pkg;

  // 50 MHz system clock, 19200 baud line
  localparam int unsigned BAUD_DIV_DEF = 2604;
  // Idle bit-times tolerated between the high and the low byte of a command
  localparam int unsigned TMO_BITS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } asm_state_t;

endpackage

// File: rtl/ble_cmd_rx_uart_rx_core.sv
// 8N1 byte receiver: RX synchroniser, baud/bit counters and receiver FSM.
//
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge on rx_s
//   START | counting to the middle of the start bit to confirm it
//   DATA  | sampling 8 data bits, LSB first, one per bit-time
//   STOP  | sampling the stop bit; good -> byte_vld, low -> frm_err
module uart_rx_core
  import ble_cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frm_err,
  output logic       rx_busy
);

  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  logic            rx_meta_q;
  logic            rx_s_q;
  logic [1:0]      fill_q;
  logic            rx_hi_seen_q;
  rx_state_t       state_q;
  logic [BW-1:0]   baud_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            byte_vld_q;
  logic            frm_err_q;

  // Two-flop synchroniser, preset high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Arm edge detection only once a real (non-preset) high level has reached rx_s.
  // fill_q tracks how many synchroniser stages hold genuine line samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q       <= 2'b00;
      rx_hi_seen_q <= 1'b0;
    end else begin
      fill_q       <= {fill_q[0], 1'b1};
      rx_hi_seen_q <= fill_q[1] & rx_s_q;
    end
  end

  // Receiver FSM with registered byte_vld / frm_err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_hi_seen_q && !rx_s_q) begin
            baud_cnt_q <= BAUD_HALF;
            state_q    <= START;
          end
        end
        START: begin
          if (baud_cnt_q == '0) begin
            if (rx_s_q) begin
              state_q <= IDLE;
            end else begin
              baud_cnt_q <= BAUD_FULL;
              bit_cnt_q  <= 3'd0;
              state_q    <= DATA;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_cnt_q == '0) begin
            shift_q    <= {rx_s_q, shift_q[7:1]};
            baud_cnt_q <= BAUD_FULL;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_cnt_q == '0) begin
            if (rx_s_q) begin
              byte_vld_q <= 1'b1;
            end else begin
              frm_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_byte  = shift_q;
  assign byte_vld = byte_vld_q;
  assign frm_err  = frm_err_q;
  assign rx_busy  = (state_q != IDLE);

endmodule

// File: rtl/ble_cmd_rx.sv
// BLE command receiver: pairs received bytes into 16-bit commands (high byte
// first) and hands them over with a cmd_rdy / clr_cmd_rdy handshake.
//
//   state   | meaning
//   WAIT_HI | no byte held; next good byte becomes the high byte
//   WAIT_LO | high byte held; next good byte completes the command
module ble_cmd_rx
  import ble_cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF,
  parameter int unsigned TMO_BITS = TMO_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int unsigned TW = $clog2(TMO_BITS * BAUD_DIV + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TMO_BITS * BAUD_DIV);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  logic [7:0]  rx_byte;
  logic        byte_vld;
  logic        rx_frm_err;
  logic        rx_busy;

  asm_state_t  asm_state_q;
  logic [7:0]  hi_byte_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [TW-1:0] tmo_cnt_d;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .rx_byte  (rx_byte),
    .byte_vld (byte_vld),
    .frm_err  (rx_frm_err),
    .rx_busy  (rx_busy)
  );

  // Saturating half-command timeout: only line-idle time counts, so a byte
  // in flight never expires the held high byte.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((asm_state_q == WAIT_LO) && !rx_busy && (tmo_cnt_q != TMO_LIMIT)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_ONE;
    end
  end

  // Assembler FSM plus cmd / cmd_rdy registers; completion overrides a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_state_q <= WAIT_HI;
      hi_byte_q   <= 8'h00;
      tmo_cnt_q   <= '0;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
    end else begin
      if (clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
      case (asm_state_q)
        WAIT_HI: begin
          tmo_cnt_q <= '0;
          if (byte_vld) begin
            hi_byte_q   <= rx_byte;
            asm_state_q <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (rx_frm_err) begin
            hi_byte_q   <= 8'h00;
            tmo_cnt_q   <= '0;
            asm_state_q <= WAIT_HI;
          end else if (byte_vld) begin
            cmd_q       <= {hi_byte_q, rx_byte};
            cmd_rdy_q   <= 1'b1;
            tmo_cnt_q   <= '0;
            asm_state_q <= WAIT_HI;
          end else if (tmo_cnt_q == TMO_LIMIT) begin
            hi_byte_q   <= 8'h00;
            tmo_cnt_q   <= '0;
            asm_state_q <= WAIT_HI;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        default: asm_state_q <= WAIT_HI;
      endcase
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = rx_frm_err;

endmodule
